// File: rtl/serial_absdiff_pkg.sv
// serial_absdiff_pkg -- shared types and constants for the bit-serial
// absolute-difference unit.
//   state_e : controller states
//   cnt_w() : width of the bit counter for a given operand width
package serial_absdiff_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_WIDTH = 8;

    // One spare bit so the counter never wraps before reaching WIDTH-1.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/serial_absdiff_if.sv
// serial_absdiff_if -- operand/result handshake bundle.
//   in_valid/in_ready/a/b      : operand channel (master -> slave)
//   out_valid/out_ready/diff/a_lt_b : result channel (slave -> master)
//   master : operand producer / result consumer
//   slave  : the absolute-difference unit
interface serial_absdiff_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             a_lt_b;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, a_lt_b
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, a_lt_b
    );
endinterface

// File: rtl/serial_absdiff_fs.sv
// serial_absdiff_fs -- one-bit full subtractor, a - b - b_in.
//   a, b  : operand bits
//   b_in  : borrow in
//   d     : difference bit
//   b_out : borrow out
// Each gate drives its own net so any single gate can be swapped out.
module serial_absdiff_fs (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);
    logic a_n;
    logic x_ab;
    logic t_nab;
    logic t_nabin;
    logic t_bbin;

    assign a_n     = ~a;
    assign x_ab    = a ^ b;
    assign d       = x_ab ^ b_in;
    assign t_nab   = a_n & b;
    assign t_nabin = a_n & b_in;
    assign t_bbin  = b & b_in;
    assign b_out   = t_nab | t_nabin | t_bbin;
endmodule

// File: rtl/serial_absdiff.sv
// serial_absdiff -- bit-serial unsigned |a-b|, one bit per clock, LSB first.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of serial_absdiff_if (operands in, result out)
//   busy     : high whenever the controller is not IDLE
// a-b is formed serially in SUB; if the final borrow is set the result
// register is two's-complemented in a second serial pass (NEG) through
// the same shifter. Latency is WIDTH clocks (a>=b) or 2*WIDTH (a<b).
module serial_absdiff
    import serial_absdiff_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_absdiff_if.slave bus,
    output logic            busy
);
    localparam int               CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;     // borrow in SUB, carry in NEG
    logic             lt_q, lt_d;

    logic fs_d;
    logic fs_bout;
    logic accept;
    logic last_bit;

    serial_absdiff_fs u_fs (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .b_in  (c_q),
        .d     (fs_d),
        .b_out (fs_bout)
    );

    assign accept   = bus.in_valid & bus.in_ready;
    assign last_bit = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                r_d   = {fs_d, r_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fs_bout;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    // Final borrow set means a<b. It also serves as the
                    // initial carry of 1 that the negation pass needs.
                    lt_d    = fs_bout;
                    cnt_d   = '0;
                    state_d = fs_bout ? NEG : DONE;
                end
            end
            NEG: begin
                // Serial ~R + 1: invert each bit and ripple the carry.
                r_d   = {~r_q[0] ^ c_q, r_q[WIDTH-1:1]};
                c_d   = ~r_q[0] & c_q;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) & ~rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = r_q;
    assign bus.a_lt_b    = lt_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_serial_absdiff.sv
// tb_serial_absdiff -- directed and randomized checks of serial_absdiff
// against an arithmetic |a-b| reference model.
module tb_serial_absdiff;
    import serial_absdiff_pkg::*;

    localparam int W = 8;
    localparam int N = 1000;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    serial_absdiff_if #(.WIDTH(W)) bus ();

    serial_absdiff #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         lt;
        int           t;
        int           lat;
    } exp_t;

    exp_t expq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One directed operation; out_ready is held low for 'hold' cycles
    // after out_valid rises.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int hold);
        logic [W-1:0] ed;
        logic         el;
        int           elat;
        int           n;
        ed   = (av >= bv) ? av - bv : bv - av;
        el   = (av < bv);
        elat = el ? 2 * W : W;
        bus.out_ready = (hold == 0);
        chk("pre_in_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        tick();
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(elat));
        chk("diff", 32'(bus.diff), 32'(ed));
        chk("a_lt_b", 32'(bus.a_lt_b), 32'(el));
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_diff", 32'(bus.diff), 32'(ed));
            chk("hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("post_valid", 32'(bus.out_valid), 0);
        chk("post_in_ready", 32'(bus.in_ready), 1);
        chk("post_diff", 32'(bus.diff), 32'(ed));
        chk("post_lt", 32'(bus.a_lt_b), 32'(el));
    endtask

    initial begin
        int spur;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = 8'd12;
        bus.b = 8'd34;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_diff", 32'(bus.diff), 0);
        chk("rst_lt", 32'(bus.a_lt_b), 0);
        chk("rst_busy", 32'(busy), 0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        do_op(8'd200, 8'd55, 0);
        do_op(8'd55, 8'd200, 0);
        do_op(8'd0, 8'd255, 0);
        do_op(8'd255, 8'd0, 0);
        do_op(8'd77, 8'd77, 0);
        do_op(8'd123, 8'd45, 5);
        do_op(8'd3, 8'd4, 0);   // accepted on the edge right after release

        // Reset in the middle of SUB aborts the operation.
        bus.in_valid = 1'b1;
        bus.a = 8'd10;
        bus.b = 8'd3;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(bus.out_valid), 0);
        chk("abort_diff", 32'(bus.diff), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 0);
        rst = 1'b0;
        spur = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.out_valid) spur++;
        end
        chk("abort_no_valid", 32'(spur), 0);
        do_op(8'd9, 8'd4, 0);

        // Randomized stream with gaps on both sides.
        fork
            begin : drv
                logic [W-1:0] av, bv;
                logic         acc;
                int           wt;
                exp_t         e;
                for (int i = 0; i < N; i++) begin
                    int gap;
                    gap = int'($urandom_range(0, 3));
                    for (int g = 0; g < gap; g++) begin
                        bus.in_valid = 1'b0;
                        bus.a = W'($urandom);
                        bus.b = W'($urandom);
                        tick();
                    end
                    av = W'($urandom);
                    bv = ($urandom_range(0, 9) == 0) ? av : W'($urandom);
                    bus.in_valid = 1'b1;
                    bus.a = av;
                    bus.b = bv;
                    wt = 0;
                    acc = 1'b0;
                    while (!acc && wt < 200) begin
                        acc = bus.in_ready;
                        tick();
                        wt++;
                    end
                    if (!acc) begin
                        chk("accept_timeout", 0, 1);
                        break;
                    end
                    e.d   = (av >= bv) ? av - bv : bv - av;
                    e.lt  = (av < bv);
                    e.t   = cyc;
                    e.lat = e.lt ? 2 * W : W;
                    expq.push_back(e);
                    bus.in_valid = 1'b0;
                end
                bus.in_valid = 1'b0;
            end
            begin : mon
                int   got;
                int   guard;
                logic prev;
                exp_t e;
                got = 0;
                guard = 0;
                prev = 1'b0;
                while (got < N && guard < 60000) begin
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    if (bus.out_valid && !prev) begin
                        if (expq.size() == 0) chk("r_spurious", 1, 0);
                        else chk("r_latency", 32'(cyc - expq[0].t), 32'(expq[0].lat));
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        if (expq.size() == 0) begin
                            chk("r_extra", 1, 0);
                        end else begin
                            e = expq.pop_front();
                            chk("r_diff", 32'(bus.diff), 32'(e.d));
                            chk("r_lt", 32'(bus.a_lt_b), 32'(e.lt));
                        end
                        got++;
                    end
                    prev = bus.out_valid;
                    tick();
                    guard++;
                end
                chk("r_count", 32'(got), 32'(N));
            end
        join
        chk("r_leftover", 32'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_absdiff.md
Name: serial_absdiff

Overview:
- Bit-serial unsigned absolute-difference unit, |a-b|, for the Sobel gradient-magnitude path.
- Counterpart of the one-bit full-adder cell: built around a one-bit full-subtractor cell, processing one bit per clock, LSB first.
- Trades latency for area.
- Valid/ready handshake on both sides, so it chains with pixel-pipeline stages.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands a/b valid
in_ready  out  1  unit can accept operands
a  in  WIDTH  unsigned minuend
b  in  WIDTH  unsigned subtrahend
out_valid  out  1  diff/a_lt_b valid
out_ready  in  1  consumer accepts result
diff  out  WIDTH  |a-b|, unsigned
a_lt_b  out  1  1 when a < b
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Both are fixed.
- States: IDLE, SUB, NEG, DONE.
- Reset: state=IDLE; out_valid=0, diff=0, a_lt_b=0, busy=0, bit counter=0, borrow/carry flop=0.
  - in_ready=0 while rst is high.
  - Reset asserted mid-operation aborts the computation. No out_valid is produced for the aborted operands.
- in_ready = (state==IDLE) & ~rst. Operands are accepted only on an edge where in_valid & in_ready.
- IDLE, on accept:
  - Load shift registers A<=a, B<=b.
  - Clear borrow and counter.
  - Go to SUB.
- SUB, one cycle per bit:
  - Full-subtract A[0], B[0], borrow: d = A0^B0^bin; bout = (~A0&B0)|(~A0&bin)|(B0&bin).
  - R <= {d, R[WIDTH-1:1]}; A and B shift right; borrow <= bout; counter++.
  - On the WIDTH-th SUB cycle, latch a_lt_b <= bout and clear the counter.
  - Next state: NEG if bout=1, else DONE.
- NEG: two's-complement R bit-serially.
  - Carry starts at 1.
  - Per cycle: s = ~R0 ^ c; c <= ~R0 & c; R <= {s, R[WIDTH-1:1]}.
  - After WIDTH cycles go to DONE.
- DONE:
  - out_valid=1; diff=R; a_lt_b stays stable.
  - Hold until out_ready=1, then go to IDLE and drop out_valid on that edge.
  - diff and a_lt_b keep their last value in IDLE (not cleared).
- Latency from the accept edge to out_valid high:
  - exactly WIDTH clocks if a>=b;
  - exactly 2*WIDTH clocks if a<b.
- Throughput: in_ready is 0 in DONE. A new operand pair is accepted no earlier than the cycle after the out_ready handshake.
- Arithmetic:
  - The result always fits in WIDTH bits unsigned.
  - a==b gives diff=0, a_lt_b=0, with no NEG pass.
  - Negation of 0 cannot occur.
- in_valid, a and b are ignored outside IDLE. Operand changes mid-operation have no effect.
- out_ready is ignored outside DONE.

Decomposition:
- Shared package: state enum (IDLE=2'd0, SUB=2'd1, NEG=2'd2, DONE=2'd3) and counter width constant CNT_W = $clog2(WIDTH)+1.
- One sub-module: fs, a one-bit full subtractor.
  - Inputs: a, b, b_in. Outputs: d, b_out.
  - Internal gates wired like the existing one-bit cells, so each gate can be individually fault-substituted.
- The NEG pass reuses the same datapath shifter. No second arithmetic cell is needed beyond the inline invert/carry.

Test Plan:
- WIDTH=8, a=200, b=55, out_ready=1 -> out_valid exactly 8 clocks after accept; diff=145, a_lt_b=0.
- a=55, b=200 -> out_valid 16 clocks after accept; diff=145, a_lt_b=1.
- Boundaries:
  - a=0, b=255 -> diff=255, a_lt_b=1.
  - a=255, b=0 -> diff=255, a_lt_b=0.
  - a=b=77 -> diff=0, a_lt_b=0, latency 8.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid.
  - diff/out_valid stay stable and in_ready stays 0.
  - Raise out_ready: next cycle in_ready=1; a new pair is accepted on the following edge.
- Reset mid-SUB:
  - Assert rst at bit 3 of a=10, b=3 -> next cycle state IDLE, out_valid=0, diff=0.
  - No spurious out_valid afterwards.
  - Fresh operands a=9, b=4 then yield diff=5.
- Randomized back-to-back stream, 1000 pairs, random in_valid/out_ready gaps -> every result equals |a-b| with correct a_lt_b, in order, none dropped or duplicated.
